fir_sample_mem: RTL and testbench

Sample-memory responder for the FIR engines. Services the engine's read port A (1-cycle registered read) and write port B. Also provides a host command/stream interface that bulk-loads input samples before a run and dumps filtered results after it. Sits between the host link and fir_non_pipelined / future pipelined FIR variants.

---
 rtl/fir_pkg.sv | 7 +
 rtl/fir_skid_fifo.sv | 34 +++
 rtl/fir_sample_mem.sv | 121 ++++++++++++
 tb/tb_fir_sample_mem.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, host op codes and sample-memory FSM states.
package fir_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    typedef enum logic {OP_LOAD = 1'b0, OP_DUMP = 1'b1} host_op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DUMP, ST_DONE} state_e;
endpackage

// File: rtl/fir_skid_fifo.sv
// fir_skid_fifo: 2-entry FIFO buffering dump read data against host backpressure.
module fir_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);
    logic [DATA_W-1:0] ent_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                ent_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end
    assign data_o  = ent_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/fir_sample_mem.sv
// fir_sample_mem: FIR sample RAM serving engine ports A/B plus host bulk LOAD/DUMP streams.
module fir_sample_mem
    import fir_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_addr_a,
    output logic [DATA_W-1:0] mem_data_out_a,
    input  logic [ADDR_W-1:0] mem_addr_b,
    input  logic [DATA_W-1:0] mem_data_in_b,
    input  logic              mem_we_b,
    input  logic              engine_busy,
    input  logic              host_cmd_valid,
    output logic              host_cmd_ready,
    input  logic              host_cmd_op,
    input  logic [ADDR_W-1:0] host_base_addr,
    input  logic [ADDR_W-1:0] host_len,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_rd_valid,
    input  logic              host_rd_ready,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              host_done,
    output logic              err_conflict
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, cnt_q, cnt_d, issued_q, issued_d;
    logic              inflight_q, err_q;
    logic [DATA_W-1:0] rdata_q, wdata;
    logic [ADDR_W-1:0] raddr, waddr;
    logic              accept, wr_hs, pop, issue, we;
    logic [1:0]        fifo_count;
    logic [2:0]        credit;

    assign host_cmd_ready = rst_n && state_q == ST_IDLE && !engine_busy;
    assign accept         = host_cmd_valid && host_cmd_ready;
    assign host_wr_ready  = state_q == ST_LOAD;
    assign wr_hs          = host_wr_valid && host_wr_ready;
    assign host_rd_valid  = fifo_count != 2'd0;
    assign pop            = host_rd_valid && host_rd_ready;
    // A pop this cycle frees a slot in time for a read issued now, giving 1 byte/cycle.
    assign credit         = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue          = state_q == ST_DUMP && issued_q != len_q && credit < 3'(FIFO_DEPTH);
    assign raddr          = state_q == ST_DUMP ? base_q + issued_q : mem_addr_a;
    assign we             = state_q == ST_IDLE ? mem_we_b : wr_hs;
    assign waddr          = state_q == ST_IDLE ? mem_addr_b : base_q + cnt_q;
    assign wdata          = state_q == ST_IDLE ? mem_data_in_b : host_wr_data;
    assign host_done      = state_q == ST_DONE;
    assign err_conflict   = err_q;
    assign mem_data_out_a = rdata_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                base_d   = host_base_addr;
                len_d    = host_len;
                cnt_d    = '0;
                issued_d = '0;
                state_d  = host_len == '0 ? ST_DONE :
                           host_op_e'(host_cmd_op) == OP_DUMP ? ST_DUMP : ST_LOAD;
            end
            ST_LOAD: if (wr_hs) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == len_q - 1'b1 ? ST_DONE : ST_LOAD;
            end
            ST_DUMP: begin
                issued_d = issue ? issued_q + 1'b1 : issued_q;
                cnt_d    = pop ? cnt_q + 1'b1 : cnt_q;
                state_d  = pop && cnt_q == len_q - 1'b1 ? ST_DONE : ST_DUMP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            issued_q   <= issued_d;
            inflight_q <= issue;
            rdata_q    <= mem[raddr];
            err_q      <= err_q || (mem_we_b && state_q != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    fir_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (inflight_q),
        .data_i (rdata_q),
        .pop_i  (pop),
        .data_o (host_rd_data),
        .count_o(fifo_count)
    );
endmodule

// File: tb/tb_fir_sample_mem.sv
// tb_fir_sample_mem: directed plus randomized checks of fir_sample_mem against an array model.
module tb_fir_sample_mem;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] mem_addr_a = '0, mem_addr_b = '0, host_base_addr = '0, host_len = '0;
    logic [7:0] mem_data_out_a, mem_data_in_b = '0, host_wr_data = '0, host_rd_data;
    logic       mem_we_b = 1'b0, engine_busy = 1'b0, host_cmd_valid = 1'b0, host_cmd_op = 1'b0;
    logic       host_cmd_ready, host_wr_valid = 1'b0, host_wr_ready, host_rd_valid;
    logic       host_rd_ready = 1'b0, host_done, err_conflict;

    logic [7:0] model [1024];
    logic [7:0] ld_q [$];
    bit         pat [6] = '{1, 0, 0, 1, 0, 1};
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fir_sample_mem dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr_a(mem_addr_a), .mem_data_out_a(mem_data_out_a),
        .mem_addr_b(mem_addr_b), .mem_data_in_b(mem_data_in_b), .mem_we_b(mem_we_b),
        .engine_busy(engine_busy),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready), .host_cmd_op(host_cmd_op),
        .host_base_addr(host_base_addr), .host_len(host_len),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_data(host_wr_data),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_data(host_rd_data),
        .host_done(host_done), .err_conflict(err_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_douta"}, mem_data_out_a, 0);
        chk({tag, "_cmdrdy"}, host_cmd_ready, 0);
        chk({tag, "_wrrdy"}, host_wr_ready, 0);
        chk({tag, "_rdv"}, host_rd_valid, 0);
        chk({tag, "_rdd"}, host_rd_data, 0);
        chk({tag, "_done"}, host_done, 0);
        chk({tag, "_err"}, err_conflict, 0);
    endtask

    task automatic cmd(input bit op, input logic [9:0] base, input int len);
        host_cmd_valid = 1'b1;
        host_cmd_op    = op;
        host_base_addr = base;
        host_len       = 10'(len);
        #1;
        for (int k = 0; k < 100 && !host_cmd_ready; k++) begin
            step();
            #1;
        end
        chk("cmd_ready", host_cmd_ready, 1);
        step();
        host_cmd_valid = 1'b0;
    endtask

    task automatic eng_read(input logic [9:0] a);
        mem_addr_a = a;
        step();
        chk("eng_read", mem_data_out_a, model[a]);
    endtask

    task automatic do_load(input logic [9:0] base, input bit gaps, input bit conflict);
        int  i = 0, cyc = 0;
        bit  hs;
        cmd(1'b0, base, ld_q.size());
        while (i < ld_q.size() && cyc < 200) begin
            host_wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            host_wr_data  = ld_q[i];
            if (conflict && i == 0) begin
                mem_we_b      = 1'b1;
                mem_addr_b    = 10'h000;
                mem_data_in_b = 8'hEE;
            end
            #1;
            chk("load_wr_ready", host_wr_ready, 1);
            hs = host_wr_valid;
            step();
            mem_we_b = 1'b0;
            if (hs) begin
                model[base + 10'(i)] = ld_q[i];
                i++;
            end
            cyc++;
        end
        host_wr_valid = 1'b0;
        chk("load_count", i, ld_q.size());
        chk("load_done", host_done, 1);
        step();
        chk("load_done_clr", host_done, 0);
    endtask

    task automatic do_dump(input logic [9:0] base, input int len, input int mode, input bit busy_mid);
        int got = 0, cyc = 0;
        bit stall_prev = 0;
        cmd(1'b1, base, len);
        if (busy_mid) engine_busy = 1'b1;
        chk("dump_v_c1", host_rd_valid, 0);
        step();
        chk("dump_v_c2", host_rd_valid, 0);
        step();
        chk("dump_first_valid", host_rd_valid, 1);
        while (got < len && cyc < 400) begin
            host_rd_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 6] : 1'($urandom_range(0, 1));
            #1;
            if (stall_prev) chk("dump_stall_hold", host_rd_valid, 1);
            if (host_rd_valid) chk("dump_data", host_rd_data, model[base + 10'(got)]);
            stall_prev = host_rd_valid && !host_rd_ready;
            if (host_rd_valid && host_rd_ready) got++;
            cyc++;
            step();
        end
        host_rd_ready = 1'b0;
        chk("dump_count", got, len);
        if (mode == 0) chk("dump_rate", cyc, len);
        chk("dump_done", host_done, 1);
        chk("dump_no_extra", host_rd_valid, 0);
        step();
        chk("dump_done_clr", host_done, 0);
        engine_busy = 1'b0;
    endtask

    initial begin
        int got;
        logic [9:0] b;
        int l;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_ready", host_cmd_ready, 1);

        ld_q = '{8'd10, 8'd20, 8'd30, 8'd20, 8'd10};
        do_load(10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) eng_read(10'(i));

        ld_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_load(10'h3FE, 1'b0, 1'b0);
        chk("wrap_model", model[10'h001], 4);
        do_dump(10'h3FE, 4, 0, 1'b0);

        ld_q = {};
        for (int i = 0; i < 6; i++) ld_q.push_back(8'($urandom));
        do_load(10'h200, 1'b1, 1'b0);
        do_dump(10'h200, 6, 1, 1'b1);

        engine_busy    = 1'b1;
        host_cmd_valid = 1'b1;
        host_cmd_op    = 1'b1;
        host_len       = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("busy_blocks_cmd", host_cmd_ready, 0);
            step();
        end
        engine_busy = 1'b0;
        cmd(1'b1, 10'h050, 0);
        chk("len0_done", host_done, 1);
        chk("len0_no_rd", host_rd_valid, 0);
        chk("len0_no_wr", host_wr_ready, 0);
        step();
        chk("len0_done_clr", host_done, 0);
        chk("len0_no_rd2", host_rd_valid, 0);

        mem_we_b = 1'b1; mem_addr_b = 10'h010; mem_data_in_b = 8'h55;
        step();
        mem_we_b = 1'b0;
        model[10'h010] = 8'h55;
        eng_read(10'h010);
        mem_addr_a = 10'h010;
        mem_we_b = 1'b1; mem_addr_b = 10'h010; mem_data_in_b = 8'h66;
        step();
        mem_we_b = 1'b0;
        chk("read_first", mem_data_out_a, 8'h55);
        model[10'h010] = 8'h66;
        eng_read(10'h010);
        chk("err_clean", err_conflict, 0);

        ld_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        do_load(10'h020, 1'b0, 1'b1);
        chk("err_set", err_conflict, 1);
        eng_read(10'h000);
        for (int i = 0; i < 3; i++) eng_read(10'h020 + 10'(i));
        chk("err_sticky", err_conflict, 1);

        for (int it = 0; it < 6; it++) begin
            b = 10'($urandom_range(0, 1023));
            l = $urandom_range(1, 8);
            ld_q = {};
            for (int i = 0; i < l; i++) ld_q.push_back(8'($urandom));
            do_load(b, 1'b1, 1'b0);
            do_dump(b, l, 2, 1'b0);
            eng_read(b + 10'($urandom_range(0, l - 1)));
        end

        ld_q = {};
        for (int i = 0; i < 5; i++) ld_q.push_back(8'($urandom));
        do_load(10'h100, 1'b0, 1'b0);
        cmd(1'b1, 10'h100, 5);
        host_rd_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got < 2; k++) begin
            #1;
            if (host_rd_valid) got++;
            step();
        end
        chk("mid_pops", got, 2);
        host_rd_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        step();
        chk("mid_reset_done", host_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_reset_done", host_done, 0);
            chk("post_reset_rdv", host_rd_valid, 0);
        end
        do_dump(10'h100, 5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
